// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Grants are combinational; each owner may stream up to MAX_BURST words per turn.
module fifo_wr_arbiter #(
    parameter  int WIDTH     = 8,
    parameter  int NREQ      = 4,
    parameter  int MAX_BURST = 4,
    localparam int CH_W      = $clog2(NREQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*WIDTH-1:0]   i_req_data,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ-1:0]         i_chan_en,
    input  logic                    i_wr_full,
    output logic                    o_wr_inc,
    output logic [CH_W+WIDTH-1:0]   o_wr_data,
    output logic                    o_busy,
    output logic [CH_W-1:0]         o_owner,
    output logic [15:0]             o_stall_cnt
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nx;
    logic [CH_W-1:0] owner, owner_nx, cand;
    logic [7:0]      burst_cnt, burst_nx;
    logic [15:0]     stall_cnt;
    logic [NREQ-1:0] eligible;
    logic            found, grant;

    assign eligible = i_req_valid & i_chan_en;

    // Search starts one past the last owner so the owner itself is checked last.
    always_comb begin
        found = 1'b0;
        cand  = owner;
        if (state == OWN) begin
            found = eligible[owner];
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                if (!found && eligible[(int'(owner) + i) % NREQ]) begin
                    found = 1'b1;
                    cand  = CH_W'((int'(owner) + i) % NREQ);
                end
            end
        end
    end

    assign grant = found && !i_wr_full && !i_rst;

    always_comb begin
        o_req_ready = '0;
        o_wr_inc    = grant;
        o_wr_data   = '0;
        if (grant) begin
            o_req_ready[cand] = 1'b1;
            o_wr_data         = {cand, i_req_data[cand*WIDTH +: WIDTH]};
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        burst_nx = burst_cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    owner_nx = cand;
                    burst_nx = 8'd1;
                    state_nx = (MAX_BURST == 1) ? IDLE : OWN;
                end
            end
            OWN: begin
                if (grant) begin
                    burst_nx = burst_cnt + 8'd1;
                    if (burst_nx == 8'(MAX_BURST))
                        state_nx = IDLE;
                end else if (!i_wr_full && !eligible[owner]) begin
                    // Owner went away: give up the port, costing one bubble.
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            owner     <= CH_W'(NREQ - 1);
            burst_cnt <= 8'd0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            burst_cnt <= burst_nx;
            if (i_wr_full && (|eligible) && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_busy      = (state == OWN);
    assign o_owner     = owner;
    assign o_stall_cnt = stall_cnt;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the FIR block's dual-clock sample FIFO among NREQ sample producers (ADC channels, test-pattern source, coefficient loader). It runs entirely in the FIFO write-clock domain and grants the port with a bounded burst per requester. It drives the FIFO's write-increment and data inputs, tagging each word with its source channel. It also honours the FIFO full flag and counts back-pressure cycles for debug.

## Interface
- WIDTH, 8: payload width per requester.
- NREQ, 4: number of requesters, 2..16.
- MAX_BURST, 4: max consecutive transfers per grant, 1..255.
- CH_W (derived, localparam): $clog2(NREQ); channel-tag width.

- i_clk  in  1  FIFO write clock; only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester data valid.
- i_req_data  in  NREQ*WIDTH  requester k in bits [k*WIDTH +: WIDTH].
- o_req_ready  out  NREQ  one-hot or zero; transfer on valid&ready.
- i_chan_en  in  NREQ  per-channel enable; disabled channels are never granted.
- i_wr_full  in  1  FIFO full flag (write domain).
- o_wr_inc  out  1  FIFO write strobe.
- o_wr_data  out  CH_W+WIDTH  {channel id, payload}; FIFO WIDTH must equal CH_W+WIDTH.
- o_busy  out  1  1 in state OWN.
- o_owner  out  CH_W  current/last owner id.
- o_stall_cnt  out  16  saturating back-pressure cycle count.

## Operation
- State: FSM {IDLE, OWN}, owner (CH_W), burst_cnt (8 bit), stall_cnt (16 bit).
- Eligible(k) = i_req_valid[k] & i_chan_en[k].
- Candidate selection, combinational:
  - In OWN, only owner is a candidate, if Eligible(owner).
  - In IDLE, the candidate is the first eligible k searching owner+1, owner+2, … mod NREQ, wrapping. owner itself is searched last.
- Grant happens when a candidate exists, i_wr_full=0 and i_rst=0. On grant:
  - o_req_ready = one-hot(candidate).
  - o_wr_inc = 1.
  - o_wr_data = {candidate, i_req_data[candidate]}.
- With no grant, o_req_ready=0, o_wr_inc=0 and o_wr_data=0.
- Transitions:
  - IDLE + grant(k): owner←k, burst_cnt←1; state←OWN, or stays IDLE if MAX_BURST==1.
  - OWN + grant: burst_cnt+1. If it reaches MAX_BURST, state←IDLE (owner kept as the rotation origin).
  - OWN with no grant and i_wr_full=1 (stall): state and owner held. Ownership is never lost to back-pressure.
  - OWN with no grant, i_wr_full=0 and owner not eligible (valid low or channel disabled): state←IDLE. This produces one bubble cycle, and other requesters are not granted in that cycle.
  - IDLE with no grant: hold.
- stall_cnt increments when i_wr_full=1 and any channel is eligible; it saturates at 16'hFFFF.
- Reset: state IDLE, owner=NREQ-1 (so the first search starts at 0), burst_cnt=0, stall_cnt=0.
- Outputs during and after reset: o_busy=0, o_owner=NREQ-1, o_stall_cnt=0, o_req_ready=0, o_wr_inc=0, o_wr_data=0.

## Timing
- Grant path is combinational. o_wr_inc and o_req_ready respond in the same cycle to i_req_valid, i_chan_en and i_wr_full; there is zero-cycle latency from valid to FIFO write.
- All state updates happen on the rising edge of i_clk. o_busy, o_owner and o_stall_cnt are registered.
- No write is issued in any cycle with i_wr_full=1. This guarantees no data loss given the FIFO's registered full flag.
- i_rst asserted mid-burst: the same cycle forces o_wr_inc=0 and o_req_ready=0. State is cleared at the next edge, and no partial transfer is recorded.
- Throughput: one word per cycle while the owner streams. A rotation after a burst costs no cycle; loss of owner-valid costs exactly 1 cycle.
- Requesters must hold valid and data stable until ready. The arbiter never asserts ready without valid.

## Test plan
- Reset: assert i_rst 3 cycles with all requesters valid -> o_wr_inc=0, o_req_ready=0, o_owner=3, o_busy=0, o_stall_cnt=0.
- Fair rotation (NREQ=4, MAX_BURST=4), requesters 0 and 1 valid continuously, full=0 -> tag sequence 0,0,0,0,1,1,1,1,0,… with o_wr_inc=1 every cycle.
- Back-pressure: full=1 for 5 cycles after the 2nd transfer of owner 2 -> no strobes, o_busy=1, o_owner=2, o_stall_cnt=5. After release, owner 2 completes 2 more words, then rotation.
- Owner drop: owner 1 deasserts valid after 2 words, requesters 0 and 3 valid -> 1 bubble cycle, then requester 3 is granted (3 precedes wrap to 0).
- Channel enable: i_chan_en[2]=0 with 2 valid -> 2 is never granted. Clearing en[0] mid-burst -> o_busy falls next edge, and the next grant goes to the next eligible requester.
- Saturation and reset mid-burst: full=1 for 70000 cycles with eligible requesters -> o_stall_cnt=16'hFFFF. Then pulsing i_rst during a burst -> outputs return to reset values, and the first grant afterwards goes to the lowest-index eligible requester.
